// File: rtl/mdu_if.sv
// Bundles the E-stage to MDU connection: operands, opcode, cancel, and the
// issue/busy/HI/LO results returned to the pipeline and the hazard unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, Op, Req, input Start, Busy, HI, LO);
  modport slave  (input A, B, Op, Req, output Start, Busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Define MDU_MADD_EN to add madd (Op 7), which accumulates into {HI,LO}.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      a_q, a_nxt, b_q, b_nxt;
  logic [3:0]       op_q, op_nxt;
  logic [31:0]      hi, hi_nxt, lo, lo_nxt;
  logic             busy, busy_nxt;
  logic             issue_op;
  logic             start;

  logic [63:0]      prod_s, prod_u;
  logic [31:0]      quot_s, rem_s, quot_u, rem_u;
`ifdef MDU_MADD_EN
  logic [63:0]      madd_sum;
`endif

  // Opcodes that occupy the unit for multiple cycles
  always_comb begin
    issue_op = 1'b0;
    case (bus.Op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: issue_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:                            issue_op = 1'b1;
`endif
      default:                            issue_op = 1'b0;
    endcase
  end

  assign start     = issue_op & ~bus.Req & ~busy & ~reset;
  assign bus.Start = start;
  assign bus.Busy  = busy;
  assign bus.HI    = hi;
  assign bus.LO    = lo;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
`ifdef MDU_MADD_EN
  assign madd_sum = {hi, lo} + prod_s;
`endif

  // Division on latched operands; the INT_MIN / -1 overflow is pinned explicitly
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_q != '0) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = '0;
      end else begin
        quot_s = 32'($signed(a_q) / $signed(b_q));
        rem_s  = 32'($signed(a_q) % $signed(b_q));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      op_q  <= op_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      busy  <= busy_nxt;
    end
  end

  // Issue, countdown and commit; moves to HI/LO only land while idle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    hi_nxt    = hi;
    lo_nxt    = lo;
    busy_nxt  = busy;
    if (state == IDLE) begin
      if (start) begin
        state_nxt = RUN;
        busy_nxt  = 1'b1;
        a_nxt     = bus.A;
        b_nxt     = bus.B;
        op_nxt    = bus.Op;
        cnt_nxt   = (bus.Op == OP_DIV || bus.Op == OP_DIVU) ? CNT_W'(DIV_CYCLES)
                                                            : CNT_W'(MULT_CYCLES);
      end else if (!bus.Req) begin
        if (bus.Op == OP_MTHI) hi_nxt = bus.A;
        else if (bus.Op == OP_MTLO) lo_nxt = bus.A;
      end
    end else begin
      if (cnt == CNT_W'(1)) begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
        case (op_q)
          OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
          OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
          OP_DIV: if (b_q != '0) begin
            lo_nxt = quot_s;
            hi_nxt = rem_s;
          end
          OP_DIVU: if (b_q != '0) begin
            lo_nxt = quot_u;
            hi_nxt = rem_u;
          end
`ifdef MDU_MADD_EN
          OP_MADD:  {hi_nxt, lo_nxt} = madd_sum;
`endif
          default: ;
        endcase
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: issue timing, HI/LO results,
// cancellation, moves, mid-operation reset and the optional madd.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    bus.Op  = op;
    bus.A   = a;
    bus.B   = b;
    bus.Req = req;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(OP_MULT, 32'd3, 32'd4, 1'b0);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Start !== 1'b0 || bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: Start=%b Busy=%b HI=%h LO=%h want 0 0 0 0",
               bus.Start, bus.Busy, bus.HI, bus.LO);
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_mult();
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.Start !== 1'b1) begin
      errors++;
      $display("FAIL mult_start: got %b want 1", bus.Start);
    end
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      drive(OP_NONE, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.Busy !== 1'b1 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
        errors++;
        $display("FAIL mult_busy_t+%0d: Busy=%b HI=%h LO=%h want 1 0 0", i, bus.Busy, bus.HI, bus.LO);
      end
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: Busy=%b HI=%h LO=%h want 0 ffffffff fffffffa", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_multu();
    next_cycle();
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'h1 || bus.LO !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_result: Busy=%b HI=%h LO=%h want 0 00000001 fffffffe", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_divu_mthi_busy();
    next_cycle();
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.Start !== 1'b1) begin
      errors++;
      $display("FAIL divu_start: got %b want 1", bus.Start);
    end
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      drive(OP_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.Busy !== 1'b1 || bus.Start !== 1'b0 || bus.HI !== 32'h1) begin
        errors++;
        $display("FAIL divu_busy_t+%0d: Busy=%b Start=%b HI=%h want 1 0 00000001", i, bus.Busy, bus.Start, bus.HI);
      end
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.LO !== 32'd14 || bus.HI !== 32'd2) begin
      errors++;
      $display("FAIL divu_result: Busy=%b HI=%h LO=%h want 0 00000002 0000000e", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_div_signed();
    // INT_MIN / -1, with a mult held during Busy that must not restart the unit
    next_cycle();
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    next_cycle();
    drive(OP_MULT, 32'd9, 32'd9, 1'b0);
    for (int i = 0; i < 9; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Start !== 1'b0) begin
      errors++;
      $display("FAIL div_busy_last: Busy=%b Start=%b want 1 0", bus.Busy, bus.Start);
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.LO !== 32'h8000_0000 || bus.HI !== 32'h0) begin
      errors++;
      $display("FAIL div_ovf_result: Busy=%b HI=%h LO=%h want 0 00000000 80000000", bus.Busy, bus.HI, bus.LO);
    end
    next_cycle();
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.LO !== 32'hFFFF_FFFD || bus.HI !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg_result: HI=%h LO=%h want ffffffff fffffffd", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div_zero();
    next_cycle();
    drive(OP_DIVU, 32'd5, 32'd0, 1'b0);
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL divzero_busy: Busy=%b want 1", bus.Busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL divzero_result: Busy=%b HI=%h LO=%h want 0 ffffffff fffffffd", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_req();
    next_cycle();
    drive(OP_MULT, 32'd2, 32'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.Start !== 1'b0) begin
      errors++;
      $display("FAIL req_start: got %b want 0", bus.Start);
    end
    next_cycle();
    drive(OP_MTHI, 32'h0000_AAAA, 32'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL req_no_issue: Busy=%b HI=%h LO=%h want 0 ffffffff fffffffd", bus.Busy, bus.HI, bus.LO);
    end
    next_cycle();
    drive(OP_MTLO, 32'h0000_1234, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL req_mthi_blocked: HI=%h want ffffffff", bus.HI);
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.LO !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mtlo_write: LO=%h want 00001234", bus.LO);
    end
    // Req during Busy must not abort
    next_cycle();
    drive(OP_MULT, 32'd3, 32'd5, 1'b0);
    next_cycle();
    drive(OP_MULT, 32'd7, 32'd7, 1'b1);
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Start !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'd15) begin
      errors++;
      $display("FAIL req_while_busy: Busy=%b Start=%b HI=%h LO=%h want 0 0 0 0000000f",
               bus.Busy, bus.Start, bus.HI, bus.LO);
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive(OP_DIV, 32'd100, 32'd7, 1'b0);
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_immediate: Busy=%b HI=%h LO=%h want 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_no_commit: Busy=%b HI=%h LO=%h want 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_madd();
    next_cycle();
    drive(OP_MTHI, 32'h0, 32'd0, 1'b0);
    next_cycle();
    drive(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    next_cycle();
    drive(OP_MADD, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL madd_setup: HI=%h LO=%h want 0 ffffffff", bus.HI, bus.LO);
    end
`ifdef MDU_MADD_EN
    checks++;
    if (bus.Start !== 1'b1) begin
      errors++;
      $display("FAIL madd_start: got %b want 1", bus.Start);
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1 || bus.LO !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL madd_busy: Busy=%b LO=%h want 1 ffffffff", bus.Busy, bus.LO);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'h1 || bus.LO !== 32'h0) begin
      errors++;
      $display("FAIL madd_result: Busy=%b HI=%h LO=%h want 0 00000001 0", bus.Busy, bus.HI, bus.LO);
    end
`else
    checks++;
    if (bus.Start !== 1'b0) begin
      errors++;
      $display("FAIL madd_disabled_start: got %b want 0", bus.Start);
    end
    next_cycle();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL madd_disabled_busy: got %b want 0", bus.Busy);
    end
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL madd_disabled_hold: HI=%h LO=%h want 0 ffffffff", bus.HI, bus.LO);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    test_reset();
    test_mult();
    test_multu();
    test_divu_mthi_busy();
    test_div_signed();
    test_div_zero();
    test_req();
    test_reset_mid();
    test_madd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
